cordic_req_scheduler: RTL and testbench
=======================================

Name: cordic_req_scheduler

Overview:
Shares one iterative CORDIC engine among NUM_REQ requesters using round-robin arbitration. It upscales the granted DATA_WIDTH operands to CORDIC_WIDTH, issues a start pulse, and waits for done under a watchdog. It then truncates the results back to DATA_WIDTH and returns them, tagged with the requester ID, through a valid/ready response port. It sits between the ICA update logic and the CORDIC core, and replaces the standalone output downscale stage.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
CORDIC_WIDTH, 22, CORDIC datapath width
DATA_WIDTH, 16, requester-side data width (< CORDIC_WIDTH)
MAX_WAIT, 64, maximum number of WAIT cycles before timeout (≥2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot grant/accept pulse
req_mode  in  NUM_REQ  per-requester mode: 0 = rotation, 1 = vectoring
req_x, req_y, req_z  in  NUM_REQ*DATA_WIDTH each  packed operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
cor_start  out  1  one-cycle start to the CORDIC core
cor_mode  out  1  mode to the core
cor_x, cor_y, cor_z  out  CORDIC_WIDTH each  upscaled operands
cor_done  in  1  core completion pulse
cor_x_res, cor_y_res, cor_z_res  in  CORDIC_WIDTH each  core results, valid when cor_done=1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NUM_REQ)  requester ID for the response
rsp_x, rsp_y, rsp_z  out  DATA_WIDTH each  downscaled results
err_timeout  out  1  one-cycle watchdog pulse
err_id  out  $clog2(NUM_REQ)  ID of the requester that timed out

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE.
  - All outputs go to 0; operand and result registers clear to 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Reset overrides any in-flight operation; a later cor_done is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the grant g is the first set bit searched from last_grant+1 upward, wrapping at NUM_REQ.
  - req_ready[g]=1 in this cycle only (combinational from state and req_valid).
  - Latch g, req_mode[g], and the upscaled operands: {operand, (CORDIC_WIDTH-DATA_WIDTH) zeros}, i.e. MSB-aligned and sign preserved.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE:
  - cor_start=1 for exactly one cycle.
  - cor_x/y/z and cor_mode are driven from registers and held stable from ISSUE until leaving WAIT.
  - Clear wait_cnt; go to WAIT.
- WAIT:
  - wait_cnt increments every cycle.
  - On cor_done=1: capture result bits [CORDIC_WIDTH-1 : CORDIC_WIDTH-DATA_WIDTH] of each result (truncation, no rounding or saturation) into rsp_x/y/z, set rsp_id=g, go to RESP.
  - If wait_cnt==MAX_WAIT-1 and cor_done=0: pulse err_timeout=1 for one cycle with err_id=g, set last_grant=g, return to IDLE with no response.
  - If cor_done and the timeout condition occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1 and rsp_x/y/z/id are held stable until rsp_ready=1.
  - On the handshake cycle: set last_grant=g, go to IDLE, and drop rsp_valid on the next cycle.
- cor_done outside WAIT is ignored.
- req_ready is 0 in every state other than IDLE.
- Latency: request accepted at cycle T, cor_start at T+1. With cor_done at cycle D, rsp_valid rises at D+1. The next grant can occur no earlier than the cycle after the rsp handshake.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,…,NUM_REQ-1,0,… A timed-out requester also moves the pointer.
- Exactly one job is in flight at any time; there is no queueing.

Decomposition:
- Package cordic_sched_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - localparams MODE_ROT=0 and MODE_VEC=1
  - an ID width function wrapping $clog2
- Sub-module cordic_rr_arbiter: purely combinational. Inputs are req vector and last_grant; outputs are grant_valid and grant_id. It is reusable by other shared-resource blocks.

Test Plan:
- Single request: reset, then req_valid=4'b0010 with x=16'h4000, y=16'h0000, z=16'h2000, mode=0.
  - Expect req_ready=4'b0010 for one cycle and cor_start one cycle later.
  - Expect cor_x=22'h100000 and cor_z=22'h080000.
  - Model done after 18 cycles with cor_x_res=22'h26DD3B; expect rsp_x=16'h9B74, rsp_id=1, rsp_valid the cycle after done.
- Round-robin: all four req_valid held high, rsp_ready=1, done after 5 cycles.
  - Expect grant order 0,1,2,3,0 with no repeats and no skips.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - Expect rsp data/id stable, req_ready=0 throughout, and no new cor_start until the cycle after rsp_ready=1.
- Timeout: never assert cor_done with MAX_WAIT=64.
  - Expect err_timeout pulse exactly 64 cycles after the first WAIT cycle, err_id=g, no rsp_valid.
  - Expect the next grant to go to g+1.
- Done and timeout in the same cycle: cor_done asserted at wait_cnt=63.
  - Expect a normal response and err_timeout=0.
- Reset mid-WAIT: assert reset during WAIT, then pulse cor_done.
  - Expect all outputs 0, no response, and that requester 0 is granted first afterwards.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// rtl/cordic_sched_pkg.sv - shared types, constants and helpers for the CORDIC request scheduler
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// rtl/cordic_rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req         in   NUM_REQ  request vector
//   last_grant  in   IDW      index granted most recently
//   grant_valid out  1        at least one request is set
//   grant_id    out  IDW      first set request searched from last_grant+1, wrapping
module cordic_rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        // Offsets 1..NUM_REQ visit every requester once, last_grant itself last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/cordic_req_scheduler.sv
// rtl/cordic_req_scheduler.sv - round-robin sharing of one iterative CORDIC core among several requesters
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/ready/mode       per-requester request, one-hot accept pulse, mode (0 rot, 1 vec)
//   req_x/y/z                  packed DATA_WIDTH operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cor_start/mode/x/y/z       start pulse, mode and MSB-aligned operands to the core
//   cor_done, cor_*_res        core completion pulse and CORDIC_WIDTH results
//   rsp_valid/ready/id/x/y/z   truncated results tagged with the requester id
//   err_timeout, err_id        one-cycle watchdog pulse and the id that timed out
module cordic_req_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CORDIC_WIDTH = 22,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_WAIT     = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_mode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_y,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_z,
    output logic                            cor_start,
    output logic                            cor_mode,
    output logic [CORDIC_WIDTH-1:0]         cor_x,
    output logic [CORDIC_WIDTH-1:0]         cor_y,
    output logic [CORDIC_WIDTH-1:0]         cor_z,
    input  logic                            cor_done,
    input  logic [CORDIC_WIDTH-1:0]         cor_x_res,
    input  logic [CORDIC_WIDTH-1:0]         cor_y_res,
    input  logic [CORDIC_WIDTH-1:0]         cor_z_res,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_x,
    output logic [DATA_WIDTH-1:0]           rsp_y,
    output logic [DATA_WIDTH-1:0]           rsp_z,
    output logic                            err_timeout,
    output logic [$clog2(NUM_REQ)-1:0]      err_id
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int PAD = CORDIC_WIDTH - DATA_WIDTH;
    localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    sched_state_t       state, state_next;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     cur_id;
    logic [WCW-1:0]     wait_cnt;
    logic               grant_valid;
    logic [IDW-1:0]     grant_id;
    logic               done_hit;
    logic               timeout_hit;

    cordic_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        cor_start   = 1'b0;
        rsp_valid   = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    req_ready[grant_id] = 1'b1;
                    state_next          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cor_start  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the last watchdog cycle still counts as success.
                if (cor_done) begin
                    done_hit   = 1'b1;
                    state_next = S_RESP;
                end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= IDW'(NUM_REQ - 1);
            cur_id      <= '0;
            wait_cnt    <= '0;
            cor_mode    <= MODE_ROT;
            cor_x       <= '0;
            cor_y       <= '0;
            cor_z       <= '0;
            rsp_id      <= '0;
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_z       <= '0;
            err_timeout <= 1'b0;
            err_id      <= '0;
        end else begin
            err_timeout <= 1'b0;

            if (state == S_IDLE && grant_valid) begin
                cur_id   <= grant_id;
                cor_mode <= req_mode[grant_id];
                // MSB-align so the sign bit and binary point scale stay intact.
                cor_x    <= {req_x[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH], {PAD{1'b0}}};
                cor_y    <= {req_y[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH], {PAD{1'b0}}};
                cor_z    <= {req_z[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH], {PAD{1'b0}}};
            end

            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            if (done_hit) begin
                rsp_id <= cur_id;
                rsp_x  <= cor_x_res[CORDIC_WIDTH-1 -: DATA_WIDTH];
                rsp_y  <= cor_y_res[CORDIC_WIDTH-1 -: DATA_WIDTH];
                rsp_z  <= cor_z_res[CORDIC_WIDTH-1 -: DATA_WIDTH];
            end

            // A timed-out requester still advances the pointer so it cannot starve others.
            if (timeout_hit) begin
                err_timeout <= 1'b1;
                err_id      <= cur_id;
                last_grant  <= cur_id;
            end

            if (state == S_RESP && rsp_ready) begin
                last_grant <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// tb/tb_cordic_req_scheduler.sv - directed scoreboard bench for cordic_req_scheduler
module tb_cordic_req_scheduler;

    localparam int NR = 4;
    localparam int CW = 22;
    localparam int DW = 16;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] z;
    } rsp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_mode;
    logic [NR*DW-1:0]  req_x, req_y, req_z;
    logic              cor_start, cor_mode;
    logic [CW-1:0]     cor_x, cor_y, cor_z;
    logic              cor_done;
    logic [CW-1:0]     cor_x_res, cor_y_res, cor_z_res;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_x, rsp_y, rsp_z;
    logic              err_timeout;
    logic [1:0]        err_id;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];

    cordic_req_scheduler #(
        .NUM_REQ(NR), .CORDIC_WIDTH(CW), .DATA_WIDTH(DW), .MAX_WAIT(64)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .cor_start(cor_start), .cor_mode(cor_mode),
        .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z),
        .cor_done(cor_done),
        .cor_x_res(cor_x_res), .cor_y_res(cor_y_res), .cor_z_res(cor_z_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .err_timeout(err_timeout), .err_id(err_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        cor_done  = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_start"}, 32'(cor_start), 32'd0);
        chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout), 32'd0);
        chk({tag, "_corx"}, 32'(cor_x), 32'd0);
        chk({tag, "_corz"}, 32'(cor_z), 32'd0);
        chk({tag, "_rspx"}, 32'(rsp_x), 32'd0);
        chk({tag, "_rspid"}, 32'(rsp_id), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    // Runs one job from grant to response handshake. The core model asserts
    // done at WAIT cycle wait_n (wait_cnt == wait_n). bp = backpressure cycles.
    task automatic run_job(input int exp_g, input int wait_n, input logic [CW-1:0] rx,
                           input logic [CW-1:0] ry, input logic [CW-1:0] rz,
                           input int bp, input logic [NR-1:0] next_valid);
        int            t;
        rsp_t          e;
        rsp_t          got;
        logic [DW-1:0] ox, oz;
        logic [NR-1:0] exp_rdy;
        t = 0;
        while (req_ready == '0 && t < 50) begin
            tick();
            t++;
        end
        exp_rdy = '0;
        exp_rdy[exp_g] = 1'b1;
        chk("grant", 32'(req_ready), 32'(exp_rdy));
        ox = req_x[exp_g*DW +: DW];
        oz = req_z[exp_g*DW +: DW];
        e.id = 2'(exp_g);
        e.x  = rx[CW-1 -: DW];
        e.y  = ry[CW-1 -: DW];
        e.z  = rz[CW-1 -: DW];
        sb.push_back(e);
        tick();
        chk("cor_start", 32'(cor_start), 32'd1);
        chk("ready_issue", 32'(req_ready), 32'd0);
        chk("cor_x", 32'(cor_x), 32'({ox, 6'b0}));
        chk("cor_z", 32'(cor_z), 32'({oz, 6'b0}));
        chk("cor_mode", 32'(cor_mode), 32'(req_mode[exp_g]));
        tick();
        chk("start_one_cycle", 32'(cor_start), 32'd0);
        repeat (wait_n) tick();
        chk("rspv_before_done", 32'(rsp_valid), 32'd0);
        cor_done  = 1'b1;
        cor_x_res = rx;
        cor_y_res = ry;
        cor_z_res = rz;
        tick();
        cor_done  = 1'b0;
        cor_x_res = CW'($urandom);
        cor_y_res = CW'($urandom);
        cor_z_res = CW'($urandom);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("no_timeout", 32'(err_timeout), 32'd0);
        got = sb.size() > 0 ? sb.pop_front() : '0;
        for (int b = 0; b <= bp; b++) begin
            chk("rsp_id", 32'(rsp_id), 32'(got.id));
            chk("rsp_x", 32'(rsp_x), 32'(got.x));
            chk("rsp_y", 32'(rsp_y), 32'(got.y));
            chk("rsp_z", 32'(rsp_z), 32'(got.z));
            chk("ready_resp", 32'(req_ready), 32'd0);
            chk("start_resp", 32'(cor_start), 32'd0);
            if (b < bp) begin
                tick();
                chk("rspv_held", 32'(rsp_valid), 32'd1);
            end
        end
        rsp_ready = 1'b1;
        req_valid = next_valid;
        tick();
        rsp_ready = 1'b0;
        chk("rspv_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        req_mode  = 4'b0100;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        cor_x_res = '0;
        cor_y_res = '0;
        cor_z_res = '0;
        do_reset();
        check_idle_zero("reset");

        // Single request from requester 1.
        req_x[1*DW +: DW] = 16'h4000;
        req_y[1*DW +: DW] = 16'h0000;
        req_z[1*DW +: DW] = 16'h2000;
        req_valid = 4'b0010;
        #1;
        run_job(1, 18, 22'h26DD3B, 22'h012345, 22'h3FFFC0, 0, 4'b0000);
        chk("single_rsp_ref", 32'(rsp_x), 32'h9B74);

        // Round robin with all requesters active, backpressure on the third job.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_x[i*DW +: DW] = 16'(16'h1000 * (i + 1) + i);
            req_y[i*DW +: DW] = 16'(16'h8001 + i);
            req_z[i*DW +: DW] = 16'(16'hF000 - i);
        end
        req_valid = 4'b1111;
        #1;
        run_job(0, 5, CW'($urandom), CW'($urandom), CW'($urandom), 0, 4'b1111);
        run_job(1, 5, CW'($urandom), CW'($urandom), CW'($urandom), 0, 4'b1111);
        run_job(2, 5, CW'($urandom), CW'($urandom), CW'($urandom), 10, 4'b1111);
        run_job(3, 5, CW'($urandom), CW'($urandom), CW'($urandom), 0, 4'b1111);
        run_job(0, 5, CW'($urandom), CW'($urandom), CW'($urandom), 0, 4'b1111);

        // Watchdog: requester 1 granted, core never answers.
        chk("to_grant", 32'(req_ready), 32'h2);
        tick();
        chk("to_start", 32'(cor_start), 32'd1);
        tick();
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k < 64) begin
                chk("to_early", 32'(err_timeout), 32'd0);
            end
        end
        chk("to_pulse", 32'(err_timeout), 32'd1);
        chk("to_id", 32'(err_id), 32'd1);
        chk("to_no_rsp", 32'(rsp_valid), 32'd0);
        chk("to_next_grant", 32'(req_ready), 32'h4);

        // Done in the final watchdog cycle wins; next requester is 2.
        run_job(2, 63, CW'($urandom), CW'($urandom), CW'($urandom), 0, 4'b1000);
        tick();
        chk("tie_no_pulse", 32'(err_timeout), 32'd0);

        // Reset in the middle of WAIT for requester 3, then a stray done.
        chk("mid_grant", 32'(req_ready), 32'd0);
        tick();
        tick();
        req_valid = 4'b0000;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("mid_reset");
        cor_done  = 1'b1;
        cor_x_res = 22'h3FFFFF;
        tick();
        cor_done = 1'b0;
        repeat (3) begin
            chk("stray_done_rspv", 32'(rsp_valid), 32'd0);
            chk("stray_done_start", 32'(cor_start), 32'd0);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        run_job(0, 2, CW'($urandom), CW'($urandom), CW'($urandom), 0, 4'b0000);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
